// File: rtl/baser_pkg.sv
// Shared constants for the BASE-R 256b/257b transmit path.
package baser_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int TC_WIDTH   = 4 * DATA_WIDTH + 1;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0]            BT_ERROR  = 8'h1E;
    localparam logic [DATA_WIDTH-1:0] BLK_ERROR = {{8{7'h1E}}, BT_ERROR};

endpackage

// File: rtl/baser_257b_transcoder_if.sv
// Block-in / transcoded-out handshake bundle for the 257b transcoder.
interface baser_257b_transcoder_if;

    logic                              i_valid;
    logic                              o_ready;
    logic [baser_pkg::DATA_WIDTH-1:0]  i_data;
    logic [1:0]                        i_sh;
    logic                              o_valid;
    logic                              i_ready;
    logic [baser_pkg::TC_WIDTH-1:0]    o_tx_coded;

    modport slave (
        input  i_valid, i_data, i_sh, i_ready,
        output o_ready, o_valid, o_tx_coded
    );

    modport master (
        output i_valid, i_data, i_sh, i_ready,
        input  o_ready, o_valid, o_tx_coded
    );

endinterface

// File: rtl/baser_257b_pack.sv
// Combinational packer: four 64b payloads plus data flags into one 257b word.
module baser_257b_pack
    import baser_pkg::*;
(
    input  logic [3:0][DATA_WIDTH-1:0] blk_i,
    input  logic [3:0]                 is_data_i,
    output logic [TC_WIDTH-1:0]        tc_o
);

    // The first control block drops its low type nibble to make room for the flags.
    always_comb begin
        tc_o = '0;
        if (&is_data_i) begin
            tc_o = {blk_i, 1'b1};
        end else if (!is_data_i[0]) begin
            tc_o = {blk_i[3], blk_i[2], blk_i[1],
                    blk_i[0][DATA_WIDTH-1:8], blk_i[0][7:4], is_data_i, 1'b0};
        end else if (!is_data_i[1]) begin
            tc_o = {blk_i[3], blk_i[2],
                    blk_i[1][DATA_WIDTH-1:8], blk_i[1][7:4], blk_i[0], is_data_i, 1'b0};
        end else if (!is_data_i[2]) begin
            tc_o = {blk_i[3],
                    blk_i[2][DATA_WIDTH-1:8], blk_i[2][7:4], blk_i[1], blk_i[0], is_data_i, 1'b0};
        end else begin
            tc_o = {blk_i[3][DATA_WIDTH-1:8], blk_i[3][7:4],
                    blk_i[2], blk_i[1], blk_i[0], is_data_i, 1'b0};
        end
    end

endmodule

// File: rtl/baser_257b_transcoder.sv
// Gathers four 66b blocks and emits one registered 257b transcoded block,
// with valid/ready on both sides and running block/error counters.
module baser_257b_transcoder
    import baser_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_rst,
    baser_257b_transcoder_if.slave bus,
    output int                     o_block_count,
    output int                     o_data_count,
    output int                     o_ctrl_count,
    output int                     o_err_count
);

    logic [1:0]                  cnt_q;
    logic [2:0][DATA_WIDTH-1:0]  buf_q;
    logic [2:0]                  flag_q;
    logic                        valid_q;
    logic [TC_WIDTH-1:0]         tc_q;
    logic [TC_WIDTH-1:0]         tc_d;
    int                          blk_cnt_q, data_cnt_q, ctrl_cnt_q, err_cnt_q;

    logic                        sh_bad, in_data, accept, last, drain;
    logic [DATA_WIDTH-1:0]       blk_in;

    always_comb begin
        sh_bad  = (bus.i_sh != SH_DATA) && (bus.i_sh != SH_CTRL);
        in_data = (bus.i_sh == SH_DATA);
        blk_in  = sh_bad ? BLK_ERROR : bus.i_data;
    end

    // Only the 4th block of a group needs the output slot, so stall only then.
    assign bus.o_ready = (cnt_q != 2'd3) || !valid_q || bus.i_ready;
    assign accept      = bus.i_valid && bus.o_ready;
    assign last        = accept && (cnt_q == 2'd3);
    assign drain       = valid_q && bus.i_ready;

    baser_257b_pack u_pack (
        .blk_i     ({blk_in, buf_q}),
        .is_data_i ({in_data, flag_q}),
        .tc_o      (tc_d)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q      <= '0;
            buf_q      <= '0;
            flag_q     <= '0;
            valid_q    <= 1'b0;
            tc_q       <= '0;
            blk_cnt_q  <= 0;
            data_cnt_q <= 0;
            ctrl_cnt_q <= 0;
            err_cnt_q  <= 0;
        end else begin
            if (drain) begin
                valid_q <= 1'b0;
                tc_q    <= '0;
            end
            if (accept) begin
                if (last) begin
                    valid_q <= 1'b1;
                    tc_q    <= tc_d;
                    cnt_q   <= '0;
                end else begin
                    buf_q[cnt_q]  <= blk_in;
                    flag_q[cnt_q] <= in_data;
                    cnt_q         <= cnt_q + 2'd1;
                end
                if (sh_bad) begin
                    err_cnt_q <= err_cnt_q + 1;
                end
            end
            if (drain) begin
                blk_cnt_q <= blk_cnt_q + 1;
                if (tc_q[0]) begin
                    data_cnt_q <= data_cnt_q + 1;
                end else begin
                    ctrl_cnt_q <= ctrl_cnt_q + 1;
                end
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_tx_coded = tc_q;
    assign o_block_count  = blk_cnt_q;
    assign o_data_count   = data_cnt_q;
    assign o_ctrl_count   = ctrl_cnt_q;
    assign o_err_count    = err_cnt_q;

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Self-checking bench for the 256b/257b transcoder: vector table plus scoreboard.
module tb_baser_257b_transcoder;

    typedef struct packed {
        logic [3:0][63:0] d;
        logic [3:0][1:0]  sh;
        logic [256:0]     exp;
    } vec_t;

    logic clk = 1'b0;
    logic i_rst;
    int   blk_cnt, data_cnt, ctrl_cnt, err_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_blk = 0, exp_data = 0, exp_ctrl = 0, exp_err = 0;
    logic [256:0] exp_q[$];
    logic         mon_en = 1'b0;

    baser_257b_transcoder_if bus ();

    baser_257b_transcoder dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .bus           (bus),
        .o_block_count (blk_cnt),
        .o_data_count  (data_cnt),
        .o_ctrl_count  (ctrl_cnt),
        .o_err_count   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference encoder: appends fields into a bit stream with a running cursor.
    function automatic logic [256:0] model(input logic [3:0][63:0] d, input logic [3:0][1:0] sh);
        logic [256:0] r;
        logic [63:0]  b [4];
        logic         isd [4];
        logic         all_d, seen;
        int           pos;
        r = '0;
        all_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (sh[k] == 2'b01) begin
                isd[k] = 1'b1; b[k] = d[k];
            end else if (sh[k] == 2'b10) begin
                isd[k] = 1'b0; b[k] = d[k];
            end else begin
                isd[k] = 1'b0; b[k] = {{8{7'h1E}}, 8'h1E};
            end
            if (!isd[k]) all_d = 1'b0;
        end
        if (all_d) begin
            r[0] = 1'b1;
            for (int k = 0; k < 4; k++) r[64*k+1 +: 64] = b[k];
        end else begin
            for (int k = 0; k < 4; k++) r[k+1] = isd[k];
            pos  = 5;
            seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!isd[k] && !seen) begin
                    seen = 1'b1;
                    r[pos +: 4]  = b[k][7:4];
                    pos += 4;
                    r[pos +: 56] = b[k][63:8];
                    pos += 56;
                end else begin
                    r[pos +: 64] = b[k];
                    pos += 64;
                end
            end
        end
        return r;
    endfunction

    task automatic send(input logic [63:0] d, input logic [1:0] sh);
        int n = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_sh    = sh;
        @(negedge clk);
        while (!bus.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: o_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        if (sh != 2'b01 && sh != 2'b10) exp_err++;
    endtask

    task automatic send_group(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(v.exp);
            send(v.d[k], v.sh[k]);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_block_count"}, 257'(blk_cnt),  257'(exp_blk));
        check({tag, "_data_count"},  257'(data_cnt), 257'(exp_data));
        check({tag, "_ctrl_count"},  257'(ctrl_cnt), 257'(exp_ctrl));
        check({tag, "_err_count"},   257'(err_cnt),  257'(exp_err));
    endtask

    // Scoreboard: any cycle about to transfer must match the oldest expected word.
    initial begin
        logic [256:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && !i_rst && bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL scoreboard: unexpected word %h, required none", bus.o_tx_coded);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_word", bus.o_tx_coded, e);
                    exp_blk++;
                    if (e[0]) exp_data++;
                    else      exp_ctrl++;
                end
            end
        end
    end

    vec_t         vecs [7];
    logic [256:0] held;
    vec_t         va, vb, vc;
    int           n;

    initial begin
        vecs[0].d  = {64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA,
                      64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[0].sh = {2'b01, 2'b01, 2'b01, 2'b01};
        vecs[1].d  = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                      64'h1111_1111_1111_1111, 64'hDEAD_BEEF_CAFE_F01E};
        vecs[1].sh = {2'b01, 2'b01, 2'b01, 2'b10};
        vecs[2].d  = {64'h5555_6666_7777_88FF, 64'h89AB_CDEF_0123_4578,
                      64'h1716_1514_1312_1110, 64'h0F0E_0D0C_0B0A_0908};
        vecs[2].sh = {2'b10, 2'b10, 2'b01, 2'b01};
        vecs[3].d  = {64'hC0C0_C0C0_C0C0_C0C0, 64'hB0B0_B0B0_B0B0_B0B0,
                      64'h0000_0000_0000_1234, 64'hA0A0_A0A0_A0A0_A0A0};
        vecs[3].sh = {2'b01, 2'b01, 2'b11, 2'b01};
        vecs[4].d  = {64'h4444_0000_0000_00D2, 64'h0000_0000_0000_0087,
                      64'hFEDC_BA98_7654_324B, 64'h0000_0000_0000_00E1};
        vecs[4].sh = {2'b10, 2'b10, 2'b10, 2'b10};
        vecs[5].d  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
                      64'h0F0F_0F0F_0F0F_0F0F, 64'h8000_0000_0000_0001};
        vecs[5].sh = {2'b00, 2'b01, 2'b01, 2'b01};
        for (int k = 0; k < 4; k++) begin
            vecs[6].d[k]  = {$urandom, $urandom};
            vecs[6].sh[k] = 2'b01;
        end
        for (int i = 0; i < 7; i++) vecs[i].exp = model(vecs[i].d, vecs[i].sh);

        // Reset held two cycles with traffic offered
        i_rst       = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 64'h1234_5678_9ABC_DEF0;
        bus.i_sh    = 2'b11;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_rst       = 1'b0;
        bus.i_valid = 1'b0;
        mon_en      = 1'b1;
        @(negedge clk);
        check("rst_o_valid", 257'(bus.o_valid), 257'(0));
        check("rst_o_ready", 257'(bus.o_ready), 257'(1));
        check("rst_tx_coded", bus.o_tx_coded, '0);
        check_counts("rst");
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send_group(vecs[i]);
            @(negedge clk);
            check("latency_o_valid", 257'(bus.o_valid), 257'(1));
            if (i == 0) begin
                check("v0_bit0", 257'(bus.o_tx_coded[0]), 257'(1));
                check("v0_payload", 257'(bus.o_tx_coded[256:1]), 257'({32{8'hAA}}));
            end
            if (i == 1) begin
                check("v1_hdr", 257'(bus.o_tx_coded[8:0]), 257'({4'h1, 4'b1110, 1'b0}));
                check("v1_b0", 257'(bus.o_tx_coded[64:9]), 257'(56'hDEAD_BEEF_CAFE_F0));
                check("v1_rest", 257'(bus.o_tx_coded[256:65]),
                      257'({64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}));
            end
            if (i == 2) begin
                check("v2_flags", 257'(bus.o_tx_coded[4:0]), 257'({4'b0011, 1'b0}));
                check("v2_type_hi", 257'(bus.o_tx_coded[136:133]), 257'(4'h7));
                check("v2_b3", 257'(bus.o_tx_coded[256:193]), 257'(64'h5555_6666_7777_88FF));
            end
            if (i == 3) begin
                check("v3_flags", 257'(bus.o_tx_coded[4:0]), 257'({4'b1101, 1'b0}));
                check("v3_err_blk", 257'(bus.o_tx_coded[128:69]), 257'({{8{7'h1E}}, 4'h1}));
            end
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("v0_block_count", 257'(blk_cnt), 257'(1));
                check("v0_data_count", 257'(data_cnt), 257'(1));
            end
            if (i == 3) check("v3_err_count", 257'(err_cnt), 257'(1));
            check_counts("vec");
        end

        // Backpressure: one word waiting, three blocks buffered, 4th stalled
        va = vecs[6];
        vb = vecs[2];
        bus.i_ready = 1'b0;
        send_group(va);
        for (int k = 0; k < 3; k++) send(vb.d[k], vb.sh[k]);
        bus.i_valid = 1'b1;
        bus.i_data  = vb.d[3];
        bus.i_sh    = vb.sh[3];
        @(negedge clk);
        held = bus.o_tx_coded;
        check("stall_word", held, va.exp);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("stall_o_ready", 257'(bus.o_ready), 257'(0));
            check("stall_stable", bus.o_tx_coded, held);
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        exp_q.push_back(vb.exp);
        send(vb.d[3], vb.sh[3]);
        @(negedge clk);
        check("replace_o_valid", 257'(bus.o_valid), 257'(1));
        check("replace_word", bus.o_tx_coded, vb.exp);
        @(posedge clk);
        #1;
        check_counts("stall");

        // Idle gap mid-group keeps the partial group
        vc = vecs[1];
        send(vc.d[0], vc.sh[0]);
        send(vc.d[1], vc.sh[1]);
        repeat (6) @(posedge clk);
        #1;
        check("gap_no_output", 257'(bus.o_valid), 257'(0));
        send(vc.d[2], vc.sh[2]);
        exp_q.push_back(vc.exp);
        send(vc.d[3], vc.sh[3]);
        @(posedge clk);
        #1;
        check_counts("gap");

        // Reset mid-group discards the partial group and clears counters
        send(vecs[5].d[0], vecs[5].sh[0]);
        send(vecs[5].d[1], vecs[5].sh[1]);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst    = 1'b0;
        exp_blk  = 0;
        exp_data = 0;
        exp_ctrl = 0;
        exp_err  = 0;
        send_group(vecs[4]);
        @(posedge clk);
        #1;
        check("midrst_block_count", 257'(blk_cnt), 257'(1));
        check_counts("midrst");

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 257'(exp_q.size()), 257'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/baser_257b_transcoder.md
# baser_257b_transcoder

Transmit-side 256b/257b transcoder for the BASE-R path. It accepts a stream of 64b/66b-encoded blocks (64-bit payload plus 2-bit sync header), groups them four at a time, and emits one 257-bit transcoded block per group. It sits between the 64b/66b encoder and the 257b link, and produces the format the 257b checker counts. A valid/ready handshake on both sides supports backpressure.

## Interface
- DATA_WIDTH, 64, payload bits per 66b block
- TC_WIDTH, 257, transcoded block width (4*DATA_WIDTH+1)
- clk  input  1  single clock; everything sampled on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  i_data/i_sh hold a block
- o_ready  output  1  block accepted when i_valid && o_ready
- i_data  input  DATA_WIDTH  66b block payload, bit 0 first transmitted; [7:0] is the block type for control blocks
- i_sh  input  2  sync header: 2'b01 data, 2'b10 control, others invalid
- o_valid  output  1  o_tx_coded holds a transcoded block
- i_ready  input  1  downstream accepts when o_valid && i_ready
- o_tx_coded  output  TC_WIDTH  transcoded block
- o_block_count, o_data_count, o_ctrl_count, o_err_count  output  int  blocks emitted / all-data emitted / with-control emitted / invalid sync headers received

## Operation
- Gather buffer: 4×64b payload plus 4 data flags; gather index cnt 0..3.
- Invalid i_sh (00/11): the block is replaced by the error control block (type 8'h1E, remaining 56 bits all 7'h1E codes), flagged as control, o_err_count +1.
- Transcoding after the 4th block is accepted (blocks b0..b3 in arrival order):
  - All four are data: [0]=1; [64k+64:64k+1]=bk.
  - Any control: [0]=0; [k+1]=1 if bk is data, 0 if control. Let f be the first control block. Blocks before f: 64 bits each. Block f: bits [7:4] of its type byte, then its bits [63:8] (60 bits). Later blocks: 64 bits each. All fields are concatenated LSB-first from bit 5.
  - Total width is always 257.
- Output register: one entry. It loads the transcoded word when the 4th block is accepted. It clears when drained with no new load.
- o_ready = (cnt<3) || !o_valid || i_ready. The buffer can never overwrite an undrained output.
- Counters update on the output transfer (o_valid && i_ready):
  - block_count +1.
  - data_count +1 if tx_coded[0]=1, else ctrl_count +1.
  - err_count updates on input acceptance.
  - All counters wrap naturally at int overflow.

## Timing
- Reset (synchronous): cnt=0, o_valid=0, o_tx_coded=0, all counters 0, o_ready=1 from the cycle after reset. Inputs presented during reset are ignored.
- Latency: o_valid rises the cycle after the edge that accepts the 4th block. o_tx_coded is registered.
- Simultaneous drain and 4th-block accept: the new word replaces the old one, and o_valid stays 1.
- Output holds stable while o_valid && !i_ready.
- i_valid low mid-group: cnt holds and the partial group is retained indefinitely.
- Reset mid-group: the partial group is discarded, and the next accepted block becomes b0.
- Throughput: one 257b block per 4 accepted cycles, sustained with i_ready=1.

## Structure
- Shared package baser_pkg:
  - SH_DATA=2'b01, SH_CTRL=2'b10
  - BLK_ERROR (type 8'h1E, 7'h1E codes)
  - DATA_WIDTH/TC_WIDTH defaults
- Sub-module baser_257b_pack: purely combinational; takes 4 payloads and 4 data flags and returns the 257b word. The transcoder owns handshake, gather and counters.

## Test plan
- Reset: assert i_rst 2 cycles with i_valid=1 -> o_valid=0, all counts 0, o_ready=1.
- Four data blocks with payload 64'hAAAA_AAAA_AAAA_AAAA, i_ready=1 -> next cycle o_valid=1, [0]=1, [256:1] all 8'hAA pattern; block_count=1, data_count=1.
- b0 control type 8'h1E, b1..b3 data -> [0]=0, [4:1]=4'b1110, [8:5]=4'h1, [64:9]=b0[63:8], [256:65]=b1..b3; ctrl_count=1.
- b0,b1 data, b2 control type 8'h78, b3 control -> [4:1]=4'b0011, [136:133]=4'h7, b3 fully present in [256:193].
- i_sh=2'b11 on b1 -> b1 encoded as BLK_ERROR, flag 0, o_err_count=1.
- i_ready=0 for 10 cycles during streaming -> o_ready drops with 3 buffered, o_tx_coded stable, no block lost or duplicated after release; counts match blocks drained.
